// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  // Largest legal BCD digit value.
  localparam logic [3:0] BCD_MAX  = 4'd9;
  // Correction added to a binary digit sum that exceeds BCD_MAX.
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder slice, shared across all digit positions by the sequencer.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       ci,
  output logic [3:0] s_d,
  output logic       co,
  output logic       invalid
);

  logic [4:0] raw;
  logic [4:0] corr;

  // Binary digit sum; above nine it is corrected by six and produces a decimal carry.
  always_comb begin
    raw     = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, ci};
    corr    = raw + {1'b0, BCD_CORR};
    s_d     = raw[3:0];
    co      = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s_d = corr[3:0];
      co  = 1'b1;
    end
    invalid = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer walking a multi-digit BCD addition LSD to MSD through one digit slice.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int DW   = 4 * NDIG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic          cout,
  output logic          err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [3:0]    dig_s;
  logic          dig_co;
  logic          dig_inv;

  // Select the operand digits addressed by the current index for the shared slice.
  always_comb begin
    dig_a = opa_q[{idx_q, 2'b00} +: 4];
    dig_b = opb_q[{idx_q, 2'b00} +: 4];
  end

  bcd_digit_adder u_slice (
    .a_d     (dig_a),
    .b_d     (dig_b),
    .ci      (carry_q),
    .s_d     (dig_s),
    .co      (dig_co),
    .invalid (dig_inv)
  );

  // Next-state logic: accept in IDLE, one digit per cycle in ADD, a single DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          err_d   = 1'b0;
          sum_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[{idx_q, 2'b00} +: 4] = dig_s;
        carry_d = dig_co;
        err_d   = err_q | dig_inv;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = dig_co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for the serial BCD adder sequencer (NDIG=4 plus an NDIG=1 instance).
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;
  localparam int DW   = 4 * NDIG;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum;
  logic          cout;
  logic          err;

  logic          start1;
  logic [3:0]    a1;
  logic [3:0]    b1;
  logic          cin1;
  logic          busy1;
  logic          done1;
  logic [3:0]    sum1;
  logic          cout1;
  logic          err1;

  int testCount = 0;
  int failCount = 0;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  bcd_serial_add_ctrl #(.NDIG(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .err   (err1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: decimal digit-by-digit addition, result packed as {err, cout, sum}.
  function automatic logic [DW+1:0] refAdd(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                           input logic ci);
    int carry = int'(ci);
    int s = 0;
    int e = 0;
    for (int i = 0; i < NDIG; i++) begin
      int ad = (int'(av) >> (4 * i)) % 16;
      int bd = (int'(bv) >> (4 * i)) % 16;
      int total = ad + bd + carry;
      if (ad > 9 || bd > 9) e = 1;
      if (total > 9) begin
        s = s + (((total + 6) % 16) << (4 * i));
        carry = 1;
      end else begin
        s = s + (total << (4 * i));
        carry = 0;
      end
    end
    return {e[0], carry[0], s[DW-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                               input logic ci, input logic st);
    a     = av;
    b     = bv;
    cin   = ci;
    start = st;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete operation: accept, scramble inputs, wait for done, compare with the reference.
  task automatic runOp(input string tag, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic ci);
    logic [DW+1:0] exp;
    int cycles;
    exp = refAdd(av, bv, ci);
    applyStimulus(av, bv, ci, 1'b1);
    tick();
    applyStimulus(DW'($urandom), DW'($urandom), 1'($urandom), 1'b0);
    cycles = 1;
    while (done !== 1'b1 && cycles < 20) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(NDIG + 1));
    checkOutput({tag, "_busyDone"}, 32'(busy), 32'd1);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(exp[DW-1:0]));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(exp[DW]));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp[DW+1]));
    tick();
    checkOutput({tag, "_doneLow"}, 32'(done), 32'd0);
    checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sumHold"}, 32'(sum), 32'(exp[DW-1:0]));
  endtask

  // Directed scenarios followed by randomized operations.
  initial begin
    logic [DW+1:0] exp;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] sumAt;
    int doneCnt;
    int doneAt;

    rst    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    runOp("basic", 16'h1234, 16'h5678, 1'b0);
    checkOutput("basic_literal", 32'(sum), 32'h6912);
    runOp("carryAll", 16'h9999, 16'h0001, 1'b0);
    checkOutput("carryAll_literal", 32'(sum), 32'h0000);
    runOp("cinOnly", 16'h0000, 16'h0000, 1'b1);
    checkOutput("cinOnly_literal", 32'(sum), 32'h0001);
    runOp("invalid", 16'h00A0, 16'h0005, 1'b0);
    checkOutput("invalid_literal", 32'(sum), 32'h0105);
    checkOutput("invalid_errHold", 32'(err), 32'd1);
    runOp("errClear", 16'h0011, 16'h0022, 1'b0);

    // A second start while busy must be ignored.
    exp = refAdd(16'h2345, 16'h4321, 1'b0);
    applyStimulus(16'h2345, 16'h4321, 1'b0, 1'b1);
    tick();
    applyStimulus(16'h1111, 16'h1111, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b1);
    tick();
    applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b0);
    doneCnt = 0;
    doneAt  = 0;
    sumAt   = '0;
    for (int k = 3; k <= 12; k++) begin
      if (done === 1'b1) begin
        doneCnt++;
        doneAt = k;
        sumAt  = sum;
      end
      tick();
    end
    checkOutput("ignore_doneCount", 32'(doneCnt), 32'd1);
    checkOutput("ignore_doneAt", 32'(doneAt), 32'(NDIG + 1));
    checkOutput("ignore_sum", 32'(sumAt), 32'(exp[DW-1:0]));

    // Start held high: one operation every NDIG+2 cycles.
    applyStimulus(16'h4444, 16'h5555, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("b2b_done_%0d", k), 32'(done),
                  32'((k == NDIG + 1) || (k == 2 * NDIG + 3)));
      if (done === 1'b1) begin
        checkOutput($sformatf("b2b_sum_%0d", k), 32'(sum), 32'h9999);
        checkOutput($sformatf("b2b_cout_%0d", k), 32'(cout), 32'd0);
      end
      if (k == 11) start = 1'b0;
      tick();
    end

    // Reset in the middle of ADD clears everything and suppresses done.
    runOp("preReset", 16'h9999, 16'h0001, 1'b0);
    applyStimulus(16'h12F4, 16'h5678, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    doneCnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0) doneCnt++;
      tick();
    end
    checkOutput("abort_noDone", 32'(doneCnt), 32'd0);
    rst = 1'b1;
    tick();
    runOp("postReset", 16'h0050, 16'h0050, 1'b0);
    checkOutput("postReset_literal", 32'(sum), 32'h0100);

    // Single-digit configuration: done two cycles after acceptance.
    start1 = 1'b1;
    a1     = 4'd9;
    b1     = 4'd9;
    cin1   = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("ndig1_doneEarly", 32'(done1), 32'd0);
    checkOutput("ndig1_busy", 32'(busy1), 32'd1);
    tick();
    checkOutput("ndig1_done", 32'(done1), 32'd1);
    checkOutput("ndig1_sum", 32'(sum1), 32'd9);
    checkOutput("ndig1_cout", 32'(cout1), 32'd1);
    checkOutput("ndig1_err", 32'(err1), 32'd0);
    tick();

    // Randomized operands, mostly valid digits with occasional illegal ones.
    for (int n = 0; n < 30; n++) begin
      ra = '0;
      rb = '0;
      for (int d = 0; d < NDIG; d++) begin
        ra[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
        rb[4*d +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      end
      runOp($sformatf("rand%0d", n), ra, rb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
